arb_requester: RTL

- Requester-side front end for the 4-way round-robin arbiter: the client end of the req/gnt protocol.
- Takes burst jobs from up to 4 local clients and raises reqN for each pending job.
- Holds reqN for exactly the granted burst length, then releases it, and issues a serialized beat stream.
- Checks the arbiter for protocol violations and starvation.

---
 rtl/arb_pkg.sv | 15 +
 rtl/arb_req_chan.sv | 110 +++++++++++
 rtl/arb_requester.sv | 95 +++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin requester front end.
package arb_pkg;
    localparam int NCH          = 4;
    localparam int CH_W         = 2;
    localparam int LEN_W_DEF    = 4;
    localparam int WAIT_W_DEF   = 6;
    localparam int MAX_WAIT_DEF = 40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        GAP  = 2'd3
    } chan_state_t;
endpackage

// File: rtl/arb_req_chan.sv
// One requester channel: job FSM, beat counter, wait/starve tracking and
// registered req/done/aborted, plus a combinational beat strobe for the top.
module arb_req_chan
    import arb_pkg::*;
#(
    parameter int LEN_W    = LEN_W_DEF,
    parameter int WAIT_W   = WAIT_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             gnt,
    output logic             req,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             starve,
    output logic             beat,
    output logic             beat_last
);

    chan_state_t       state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              starve_q, starve_d;
    logic              req_q, req_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wait_cnt_d = wait_cnt_q;
        starve_d   = starve_q;
        aborted_d  = 1'b0;
        beat       = 1'b0;
        beat_last  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d      = len;
                    wait_cnt_d = '0;
                    starve_d   = 1'b0;
                    state_d    = REQ;
                end
            end
            REQ, XFER: begin
                // Abort wins over a coincident grant: that beat is dropped.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = GAP;
                end else if (gnt) begin
                    beat = 1'b1;
                    if (cnt_q == '0) begin
                        beat_last = 1'b1;
                        state_d   = GAP;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                        state_d = XFER;
                    end
                end else if (state_q == REQ) begin
                    if (wait_cnt_q != '1) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    if (wait_cnt_d == WAIT_W'(MAX_WAIT)) begin
                        starve_d = 1'b1;
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_d  = (state_d == REQ) || (state_d == XFER);
        done_d = (state_d == GAP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wait_cnt_q <= '0;
            starve_q   <= 1'b0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wait_cnt_q <= wait_cnt_d;
            starve_q   <= starve_d;
            req_q      <= req_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign req     = req_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign aborted = aborted_q;
    assign starve  = starve_q;

endmodule

// File: rtl/arb_requester.sv
// Requester front end: NCH channels, a registered serialized beat stream and
// sticky protocol checks on the arbiter's grant vector.
module arb_requester
    import arb_pkg::*;
#(
    parameter int LEN_W    = LEN_W_DEF,
    parameter int WAIT_W   = WAIT_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       start,
    input  logic [NCH*LEN_W-1:0] len,
    input  logic [NCH-1:0]       abort,
    input  logic [NCH-1:0]       gnt,
    output logic [NCH-1:0]       req,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       done,
    output logic [NCH-1:0]       aborted,
    output logic                 beat_valid,
    output logic [CH_W-1:0]      beat_ch,
    output logic                 beat_last,
    output logic [NCH-1:0]       starve,
    output logic                 err_spurious,
    output logic                 err_multi
);

    logic [NCH-1:0]  beat_v;
    logic [NCH-1:0]  last_v;
    logic            beat_valid_q, beat_valid_d;
    logic [CH_W-1:0] beat_ch_q, beat_ch_d;
    logic            beat_last_q, beat_last_d;
    logic            err_spurious_q, err_spurious_d;
    logic            err_multi_q, err_multi_d;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        arb_req_chan #(
            .LEN_W    (LEN_W),
            .WAIT_W   (WAIT_W),
            .MAX_WAIT (MAX_WAIT)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .start     (start[i]),
            .len       (len[i*LEN_W +: LEN_W]),
            .abort     (abort[i]),
            .gnt       (gnt[i]),
            .req       (req[i]),
            .busy      (busy[i]),
            .done      (done[i]),
            .aborted   (aborted[i]),
            .starve    (starve[i]),
            .beat      (beat_v[i]),
            .beat_last (last_v[i])
        );
    end

    // Scanning downward lets the lowest beating channel own beat_ch.
    always_comb begin
        beat_ch_d   = '0;
        beat_last_d = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (beat_v[i]) begin
                beat_ch_d   = CH_W'(i);
                beat_last_d = last_v[i];
            end
        end
        beat_valid_d   = |beat_v;
        err_spurious_d = err_spurious_q | (|(gnt & ~busy));
        err_multi_d    = err_multi_q | ($countones(gnt) > 1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_valid_q   <= 1'b0;
            beat_ch_q      <= '0;
            beat_last_q    <= 1'b0;
            err_spurious_q <= 1'b0;
            err_multi_q    <= 1'b0;
        end else begin
            beat_valid_q   <= beat_valid_d;
            beat_ch_q      <= beat_ch_d;
            beat_last_q    <= beat_last_d;
            err_spurious_q <= err_spurious_d;
            err_multi_q    <= err_multi_d;
        end
    end

    assign beat_valid   = beat_valid_q;
    assign beat_ch      = beat_ch_q;
    assign beat_last    = beat_last_q;
    assign err_spurious = err_spurious_q;
    assign err_multi    = err_multi_q;

endmodule
